// File: rtl/fifo_arb_pkg.sv
// Shared constants and FSM encoding for the fifo round-robin arbiter.
package fifo_arb_pkg;

    localparam int NUM_FIFOS = 4;
    localparam int DATA_W    = 6;
    localparam int THR_W     = 5;
    localparam int CLASS_MSB = 5;
    localparam int CLASS_LSB = 4;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/fifo_rr_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_grant
    import fifo_arb_pkg::*;
(
    input  logic [NUM_FIFOS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_FIFOS-1:0] gnt_onehot,
    output logic [1:0]           gnt_idx,
    output logic                 any_gnt
);

    logic [1:0] idx;

    // NOTE: every variable driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        idx        = '0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            idx = ptr + 2'(k);
            if (!any_gnt && req[idx]) begin
                any_gnt         = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Threshold configuration, round-robin pop and class-based routing between
// four input fifos and four output fifos.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
(
    input  logic                          clk,
    input  logic                          RESET_L,
    input  logic                          init,
    input  logic [THR_W-1:0]              thr_al_full,
    input  logic [THR_W-1:0]              thr_al_empty,
    input  logic [NUM_FIFOS-1:0]          in_empty,
    input  logic [NUM_FIFOS-1:0]          in_valid,
    input  logic [NUM_FIFOS*DATA_W-1:0]   in_data,
    input  logic [NUM_FIFOS-1:0]          in_err,
    input  logic [NUM_FIFOS-1:0]          out_pause,
    input  logic [NUM_FIFOS-1:0]          out_err,
    output logic [NUM_FIFOS-1:0]          in_rd,
    output logic [NUM_FIFOS-1:0]          out_wr,
    output logic [DATA_W-1:0]             out_data,
    output logic [THR_W-1:0]              al_full_cfg,
    output logic [THR_W-1:0]              al_empty_cfg,
    output logic [2:0]                    state,
    output logic                          idle,
    output logic                          error
);

    state_t                st, st_nxt;
    logic [1:0]            rr_ptr;
    logic [1:0]            pend_idx;
    logic                  pending;
    logic [NUM_FIFOS-1:0]  req;
    logic [NUM_FIFOS-1:0]  gnt_onehot;
    logic [1:0]            gnt_idx;
    logic                  any_gnt;
    logic                  pop;
    logic                  push;
    logic                  fault;
    logic [DATA_W-1:0]     lane_word;

    assign req = ~in_empty;

    rr_grant u_grant (
        .req        (req),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    // Datapath: pop issue, and delivery of the word popped last cycle.
    always_comb begin
        fault     = (|in_err) || (|out_err);
        pop       = (st == ST_ACTIVE) && any_gnt && (out_pause == '0) && !init;
        lane_word = '0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            if (pend_idx == 2'(k)) lane_word = in_data[k*DATA_W +: DATA_W];
        end
        push     = pending && in_valid[pend_idx] && (st != ST_ERROR);
        in_rd    = pop ? gnt_onehot : '0;
        out_data = push ? lane_word : '0;
        out_wr   = '0;
        if (push) out_wr[lane_word[CLASS_MSB:CLASS_LSB]] = 1'b1;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_RESET:  st_nxt = ST_INIT;
            ST_INIT:   if (!init) st_nxt = ST_IDLE;
            ST_IDLE: begin
                if (init)                st_nxt = ST_INIT;
                else if (in_empty != '1) st_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // Leave only once the in-flight word has been delivered.
                if (!pending) begin
                    if (init)                st_nxt = ST_INIT;
                    else if (in_empty == '1) st_nxt = ST_IDLE;
                end
            end
            ST_ERROR:  st_nxt = ST_ERROR;
            default:   st_nxt = ST_RESET;
        endcase
        if (fault && st != ST_RESET) st_nxt = ST_ERROR;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            st           <= ST_RESET;
            rr_ptr       <= '0;
            pend_idx     <= '0;
            pending      <= 1'b0;
            al_full_cfg  <= '0;
            al_empty_cfg <= '0;
        end else begin
            st      <= st_nxt;
            pending <= pop && (st_nxt != ST_ERROR);
            if (pop) begin
                rr_ptr   <= gnt_idx + 2'd1;
                pend_idx <= gnt_idx;
            end
            if (st == ST_INIT) begin
                al_full_cfg  <= thr_al_full;
                al_empty_cfg <= thr_al_empty;
            end
        end
    end

    assign state = st;
    assign idle  = (st == ST_IDLE);
    assign error = (st == ST_ERROR);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench: behavioural input fifos feed the arbiter, a scoreboard
// queue holds expected pushes and a negedge monitor compares them.
module tb_fifo_rr_arbiter;
    import fifo_arb_pkg::*;

    logic        clk = 1'b0;
    logic        RESET_L;
    logic        init;
    logic [4:0]  thr_al_full, thr_al_empty;
    logic [3:0]  in_empty = 4'hF;
    logic [3:0]  in_valid = 4'h0;
    logic [23:0] in_data  = '0;
    logic [3:0]  in_err, out_pause, out_err;
    logic [3:0]  in_rd, out_wr;
    logic [5:0]  out_data;
    logic [4:0]  al_full_cfg, al_empty_cfg;
    logic [2:0]  state;
    logic        idle, error;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] wr;
        logic [5:0] data;
    } push_t;

    push_t      exp_q[$];
    logic [5:0] mem [4][16];
    int         wp [4];
    int         rp [4];

    always #5 clk = ~clk;

    fifo_rr_arbiter dut (
        .clk          (clk),
        .RESET_L      (RESET_L),
        .init         (init),
        .thr_al_full  (thr_al_full),
        .thr_al_empty (thr_al_empty),
        .in_empty     (in_empty),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_err       (in_err),
        .out_pause    (out_pause),
        .out_err      (out_err),
        .in_rd        (in_rd),
        .out_wr       (out_wr),
        .out_data     (out_data),
        .al_full_cfg  (al_full_cfg),
        .al_empty_cfg (al_empty_cfg),
        .state        (state),
        .idle         (idle),
        .error        (error)
    );

    // Input fifo model: one-cycle read latency, empty flag updated on the edge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            in_valid[i] <= 1'b0;
            if (in_rd[i] && rp[i] != wp[i]) begin
                in_valid[i]        <= 1'b1;
                in_data[i*6 +: 6]  <= mem[i][rp[i]];
                rp[i]              <= rp[i] + 1;
                in_empty[i]        <= (rp[i] + 1 == wp[i]);
            end else begin
                in_empty[i]        <= (rp[i] == wp[i]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (RESET_L === 1'b1 && out_wr !== 4'b0) begin
            if (exp_q.size() == 0) begin
                check("push_unexpected", {22'b0, out_wr, out_data}, 32'h0);
            end else begin
                push_t e;
                e = exp_q.pop_front();
                check("push_wr", out_wr, e.wr);
                check("push_data", out_data, e.data);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int lane, input logic [5:0] w);
        mem[lane][wp[lane]] = w;
        wp[lane] = wp[lane] + 1;
    endtask

    task automatic expect_push(input logic [3:0] wr, input logic [5:0] w);
        exp_q.push_back({wr, w});
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state !== s && n < 50) begin
            tick;
            n++;
        end
        check("wait_state", state, s);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] seq [5];
        int n;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        RESET_L = 1'b0; init = 1'b0; thr_al_full = '0; thr_al_empty = '0;
        in_err = '0; out_pause = '0; out_err = '0;
        #3;
        check("rst_state", state, 3'd0);
        check("rst_cfg", {al_full_cfg, al_empty_cfg}, 10'd0);
        check("rst_outs", {in_rd, out_wr, out_data, idle, error}, 0);

        // 1: threshold configuration
        @(negedge clk);
        RESET_L = 1'b1; init = 1'b1; thr_al_full = 5'd6; thr_al_empty = 5'd2;
        tick;
        check("t1_init", state, 3'd1);
        tick;
        init = 1'b0;
        tick;
        check("t1_al_full", al_full_cfg, 5'd6);
        check("t1_al_empty", al_empty_cfg, 5'd2);
        check("t1_idle_state", state, 3'd2);
        check("t1_idle", idle, 1'b1);

        // 2: round-robin over four non-empty inputs, class 0
        load(0, 6'h01); load(1, 6'h02); load(2, 6'h03); load(3, 6'h04); load(0, 6'h05);
        expect_push(4'b0001, 6'h01); expect_push(4'b0001, 6'h02);
        expect_push(4'b0001, 6'h03); expect_push(4'b0001, 6'h04);
        expect_push(4'b0001, 6'h05);
        tick;
        tick;
        check("t2_active", state, 3'd3);
        for (int k = 0; k < 5; k++) begin
            check("t2_in_rd", in_rd, seq[k]);
            tick;
            if (k == 0) check("t2_latency", {out_wr, out_data}, {4'b0001, 6'h01});
        end
        wait_state(3'd2);

        // 3: class 3 word routed to output 3
        load(2, 6'h35);
        expect_push(4'b1000, 6'h35);
        tick;
        tick;
        check("t3_in_rd", in_rd, 4'b0100);
        tick;
        check("t3_route", {out_wr, out_data}, {4'b1000, 6'h35});
        wait_state(3'd2);

        // 4: pause blocks new pops but not the in-flight push
        load(0, 6'h11); load(0, 6'h12); load(0, 6'h13);
        expect_push(4'b0010, 6'h11); expect_push(4'b0010, 6'h12); expect_push(4'b0010, 6'h13);
        tick;
        tick;
        check("t4_first_rd", in_rd, 4'b0001);
        tick;
        out_pause = 4'b0010;
        #1;
        check("t4_paused_rd", in_rd, 4'b0000);
        check("t4_inflight", {out_wr, out_data}, {4'b0010, 6'h11});
        tick;
        check("t4_hold", {in_rd, out_wr}, 8'h00);
        out_pause = 4'b0000;
        #1;
        check("t4_resume", in_rd, 4'b0001);
        tick;
        check("t4_push12", {out_wr, out_data}, {4'b0010, 6'h12});
        tick;
        check("t4_push13", {out_wr, out_data}, {4'b0010, 6'h13});
        wait_state(3'd2);

        // 5: error is sticky and drops the in-flight word
        load(1, 6'h21); load(1, 6'h22); load(1, 6'h23);
        tick;
        tick;
        check("t5_in_rd", in_rd, 4'b0010);
        in_err = 4'b1000;
        tick;
        check("t5_error_state", state, 3'd4);
        check("t5_error_flag", error, 1'b1);
        check("t5_quiet", {in_rd, out_wr}, 8'h00);
        in_err = 4'b0000; init = 1'b1;
        tick;
        tick;
        check("t5_init_ignored", state, 3'd4);
        check("t5_still_quiet", {in_rd, out_wr}, 8'h00);
        RESET_L = 1'b0;
        #1;
        check("t5_reset_state", state, 3'd0);
        check("t5_reset_error", error, 1'b0);
        init = 1'b0;
        @(negedge clk);
        RESET_L = 1'b1;

        // 6: asynchronous reset with a word in flight
        n = 0;
        while (in_rd == 4'b0 && n < 20) begin
            tick;
            n++;
        end
        check("t6_pop", in_rd, 4'b0010);
        tick;
        check("t6_pending_push", {out_wr, out_data}, {4'b0100, 6'h22});
        RESET_L = 1'b0;
        #1;
        check("t6_async_outs", {in_rd, out_wr, out_data}, 14'd0);
        check("t6_async_state", state, 3'd0);
        check("t6_async_cfg", {al_full_cfg, al_empty_cfg}, 10'd0);
        expect_push(4'b0100, 6'h23);
        @(negedge clk);
        RESET_L = 1'b1;
        tick;
        check("t6_no_push_a", out_wr, 4'b0000);
        tick;
        check("t6_no_push_b", out_wr, 4'b0000);
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            tick;
            n++;
        end
        check("t6_drained", exp_q.size(), 0);
        wait_state(3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
